// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: prescaled digit select out to the byte
// selector, optional hex decode of the returned byte, and dead-time blanked outputs.
module seg_scan_ctrl #(
  parameter int CNT_MAX = 50000,
  parameter int DEAD    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       hex_mode,
  input  logic [7:0] blank_mask,
  input  logic [7:0] mux_q,
  output logic [2:0] sel,
  output logic [7:0] dig_n,
  output logic [7:0] seg_n,
  output logic       frame_done
);

  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] DEAD_C   = CW'(DEAD);

  logic [CW-1:0] cnt;
  logic          slot_end;
  logic          in_dead;
  logic [6:0]    hex_seg;
  logic [7:0]    pattern;

  assign slot_end = (cnt == CNT_LAST);
  assign in_dead  = (cnt < DEAD_C);

  always_comb begin
    hex_seg = 7'h00;
    case (mux_q[3:0])
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      4'hF: hex_seg = 7'h71;
      default: hex_seg = 7'h00;
    endcase
  end

  assign pattern = hex_mode ? {mux_q[7], hex_seg} : mux_q;

  // Outputs keep refreshing while en is low so the frozen digit stays lit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      sel        <= 3'd0;
      dig_n      <= 8'hFF;
      seg_n      <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      if (en) begin
        if (slot_end) begin
          cnt <= '0;
          sel <= sel + 3'd1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      frame_done <= en && slot_end && (sel == 3'd7);
      dig_n      <= (in_dead || blank_mask[sel]) ? 8'hFF : ~(8'b1 << sel);
      seg_n      <= ~pattern;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CNT_MAX=4, DEAD=1: reset, scan order,
// decode table, blank mask, freeze and mid-slot reset.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, hex_mode, use_sel;
  logic [7:0] blank_mask, mux_q, mux_fixed;
  logic [2:0] sel;
  logic [7:0] dig_n, seg_n;
  logic       frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  seg_scan_ctrl #(.CNT_MAX(4), .DEAD(1)) dut (
    .clk(clk), .rst(rst), .en(en), .hex_mode(hex_mode), .blank_mask(blank_mask),
    .mux_q(mux_q), .sel(sel), .dig_n(dig_n), .seg_n(seg_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Stand-in for the byte selector: either echo the index or a fixed byte.
  assign mux_q = use_sel ? {5'b0, sel} : mux_fixed;

  typedef struct {
    logic       hex;
    logic [7:0] q;
    logic [7:0] exp_seg;
  } vec_t;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[v];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " sel"},        {5'b0, sel},        8'h00);
    check({tag, " dig_n"},      dig_n,              8'hFF);
    check({tag, " seg_n"},      seg_n,              8'hFF);
    check({tag, " frame_done"}, {7'b0, frame_done}, 8'h00);
  endtask

  // Run n edges from a fresh reset state with en=1, hex decode of the index.
  task automatic run_scan(input string tag, input logic [7:0] mask, input int n);
    logic [2:0] ps;
    logic [7:0] exp_dig;
    logic       saw_fb;
    int         pc;
    saw_fb = 1'b0;
    for (int k = 1; k <= n; k++) begin
      tick();
      pc = (k - 1) % 4;
      ps = 3'((k - 1) / 4);
      exp_dig = (pc == 0 || mask[ps]) ? 8'hFF : ~(8'b1 << ps);
      check($sformatf("%s k%0d sel", tag, k), {5'b0, sel}, 8'((k / 4) % 8));
      check($sformatf("%s k%0d dig_n", tag, k), dig_n, exp_dig);
      check($sformatf("%s k%0d seg_n", tag, k), seg_n, ~{1'b0, hex7({1'b0, ps})});
      check($sformatf("%s k%0d frame_done", tag, k), {7'b0, frame_done},
            {7'b0, (k % 32) == 0});
      if (dig_n == 8'hFB) saw_fb = 1'b1;
    end
    if (mask[2]) check({tag, " digit2 never lit"}, {7'b0, saw_fb}, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 8'h5A};
    vecs[1] = '{1'b1, 8'h8B, 8'h03};
    vecs[2] = '{1'b1, 8'h00, 8'hC0};
    vecs[3] = '{1'b1, 8'h0F, 8'h8E};
    vecs[4] = '{1'b1, 8'hF2, 8'h24};
    vecs[5] = '{1'b1, 8'h7A, 8'h88};
    vecs[6] = '{1'b0, 8'h00, 8'hFF};

    rst = 1'b1; en = 1'b1; hex_mode = 1'b1; use_sel = 1'b1;
    blank_mask = 8'h00; mux_fixed = 8'h00;

    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_vals($sformatf("reset c%0d", i));
    end
    rst = 1'b0;
    check_reset_vals("after release");

    run_scan("scan", 8'h00, 64);

    do_reset();
    blank_mask = 8'h04;
    run_scan("mask", 8'h04, 64);
    blank_mask = 8'h00;

    // Decode table with the scan frozen at digit 0.
    do_reset();
    en = 1'b0;
    use_sel = 1'b0;
    foreach (vecs[i]) begin
      hex_mode  = vecs[i].hex;
      mux_fixed = vecs[i].q;
      tick();
      check($sformatf("vec%0d seg_n", i), seg_n, vecs[i].exp_seg);
      check($sformatf("vec%0d dig_n", i), dig_n, 8'hFF);
    end

    // Freeze at sel=5, cnt=2 (22 edges after reset).
    use_sel = 1'b1; hex_mode = 1'b1;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 22; k++) tick();
    check("pre-freeze sel", {5'b0, sel}, 8'h05);
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("freeze c%0d sel", k), {5'b0, sel}, 8'h05);
      check($sformatf("freeze c%0d dig_n", k), dig_n, 8'hDF);
      check($sformatf("freeze c%0d seg_n", k), seg_n, ~{1'b0, hex7(4'h5)});
    end
    en = 1'b1;
    tick();
    check("resume +1 sel", {5'b0, sel}, 8'h05);
    check("resume +1 dig_n", dig_n, 8'hDF);
    tick();
    check("resume +2 sel", {5'b0, sel}, 8'h06);
    tick();
    check("resume +3 dig_n dead", dig_n, 8'hFF);
    check("resume +3 seg_n", seg_n, ~{1'b0, hex7(4'h6)});
    tick();
    check("resume +4 dig_n", dig_n, 8'hBF);

    // Now at sel=6, cnt=2: reset mid-slot.
    rst = 1'b1;
    tick();
    check_reset_vals("midreset");
    rst = 1'b0;
    run_scan("restart", 8'h00, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
